// File: rtl/instr_pkg.sv
// Shared opcode-class ranges, selectSize encodings and FSM state encoding
// for the instruction decode register.
`default_nettype none

package instr_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  localparam logic [1:0] SEL_I16 = 2'b00;
  localparam logic [1:0] SEL_I22 = 2'b01;
  localparam logic [1:0] SEL_I12 = 2'b10;
  localparam logic [1:0] SEL_I18 = 2'b11;

  // Lower bound of each opcode class; classes are contiguous and ascending.
  localparam logic [5:0] OPC_I22_LO = 6'h10;
  localparam logic [5:0] OPC_I12_LO = 6'h18;
  localparam logic [5:0] OPC_I18_LO = 6'h20;
  localparam logic [5:0] OPC_ILL_LO = 6'h28;

  function automatic logic [1:0] sel_size_of(input logic [5:0] op);
    if (op < OPC_I22_LO)      return SEL_I16;
    else if (op < OPC_I12_LO) return SEL_I22;
    else if (op < OPC_I18_LO) return SEL_I12;
    else if (op < OPC_ILL_LO) return SEL_I18;
    else                      return SEL_I16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// Combinational field extraction and selectSize lookup for one instruction word.
`default_nettype none

module instr_field_decode
  import instr_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [1:0]  sel_size,
  output logic [15:0] imm17,
  output logic [21:0] imm22,
  output logic [11:0] imm9,
  output logic [17:0] imm18
);

  logic unused_bits;

  assign opcode   = instr[31:26];
  assign sel_size = sel_size_of(instr[31:26]);
  assign imm17    = instr[15:0];
  assign imm22    = instr[21:0];
  assign imm9     = instr[11:0];
  assign imm18    = instr[17:0];

  // Bits 25:22 carry no field in any instruction class.
  assign unused_bits = ^instr[25:22];

endmodule

`default_nettype wire

// File: rtl/instr_decode_reg.sv
// Two-entry skid buffer between fetch and decode; head entry is decoded combinationally.
// Optional macro ILLEGAL_OP_DETECT_EN enables the illegal-opcode flag.
`default_nettype none

module instr_decode_reg
  import instr_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      opcode,
  output logic [1:0]      selectSize,
  output logic [15:0]     imm17,
  output logic [21:0]     imm22,
  output logic [11:0]     imm9,
  output logic [17:0]     imm18,
  output logic            illegal
);

  state_e          state_q;
  logic [31:0]     head_instr_q;
  logic [PC_W-1:0] head_pc_q;
  logic [31:0]     tail_instr_q;
  logic [PC_W-1:0] tail_pc_q;
  logic            push;
  logic            pop;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_pc    = head_pc_q;

  // Vacated entries are always reloaded with NOP_WORD/0 so an empty head decodes as a NOP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      head_instr_q <= NOP_WORD;
      head_pc_q    <= '0;
      tail_instr_q <= NOP_WORD;
      tail_pc_q    <= '0;
    end else if (flush) begin
      state_q      <= ST_EMPTY;
      head_instr_q <= NOP_WORD;
      head_pc_q    <= '0;
      tail_instr_q <= NOP_WORD;
      tail_pc_q    <= '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_instr_q <= in_instr;
            head_pc_q    <= in_pc;
            state_q      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_instr_q <= in_instr;
            head_pc_q    <= in_pc;
          end else if (push) begin
            tail_instr_q <= in_instr;
            tail_pc_q    <= in_pc;
            state_q      <= ST_TWO;
          end else if (pop) begin
            head_instr_q <= NOP_WORD;
            head_pc_q    <= '0;
            state_q      <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_instr_q <= tail_instr_q;
            head_pc_q    <= tail_pc_q;
            tail_instr_q <= NOP_WORD;
            tail_pc_q    <= '0;
            state_q      <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  instr_field_decode u_field_decode (
    .instr    (head_instr_q),
    .opcode   (opcode),
    .sel_size (selectSize),
    .imm17    (imm17),
    .imm22    (imm22),
    .imm9     (imm9),
    .imm18    (imm18)
  );

`ifdef ILLEGAL_OP_DETECT_EN
  assign illegal = out_valid && (opcode >= OPC_ILL_LO);
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: queue model plus directed vectors.
`default_nettype none

module tb_instr_decode_reg;

  localparam logic [31:0] NOP = 32'h4000_0055;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [1:0]  selectSize;
  logic [15:0] imm17;
  logic [21:0] imm22;
  logic [11:0] imm9;
  logic [17:0] imm18;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  instr_decode_reg #(.PC_W(32), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .opcode(opcode), .selectSize(selectSize),
    .imm17(imm17), .imm22(imm22), .imm9(imm9), .imm18(imm18), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [5:0] op);
    if (op <= 6'h0F)      return 2'b00;
    else if (op <= 6'h17) return 2'b01;
    else if (op <= 6'h1F) return 2'b10;
    else if (op <= 6'h27) return 2'b11;
    else                  return 2'b00;
  endfunction

  // Reference model: a bounded FIFO of at most two entries.
  always @(negedge reset) mq.delete();

  always @(posedge clock) begin
    if (!reset || flush) begin
      mq.delete();
    end else begin
      automatic bit do_pop  = (mq.size() > 0) && out_ready;
      automatic bit do_push = (mq.size() < 2) && in_valid;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  always @(negedge clock) begin
    automatic logic [31:0] hi = (mq.size() > 0) ? mq[0].instr : NOP;
    automatic logic [31:0] hp = (mq.size() > 0) ? mq[0].pc : 32'h0;
    automatic logic        ill = 1'b0;
`ifdef ILLEGAL_OP_DETECT_EN
    ill = (mq.size() > 0) && (hi[31:26] >= 6'h28);
`endif
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_pc", 64'(out_pc), 64'(hp));
    chk("opcode", 64'(opcode), 64'(hi[31:26]));
    chk("selectSize", 64'(selectSize), 64'(exp_sel(hi[31:26])));
    chk("imm17", 64'(imm17), 64'(hi[15:0]));
    chk("imm22", 64'(imm22), 64'(hi[21:0]));
    chk("imm9", 64'(imm9), 64'(hi[11:0]));
    chk("imm18", 64'(imm18), 64'(hi[17:0]));
    chk("illegal", 64'(illegal), 64'(ill));
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_sel_nop", 64'(selectSize), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // single push, visible next cycle
    step(1'b1, 32'h0400_1234, 32'h100, 1'b1, 1'b0);
    chk("p1_valid", 64'(out_valid), 64'd1);
    chk("p1_sel", 64'(selectSize), 64'd0);
    chk("p1_imm17", 64'(imm17), 64'h1234);
    chk("p1_pc", 64'(out_pc), 64'h100);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("p1_empty", 64'(out_valid), 64'd0);

    // fill to TWO, third push held off
    step(1'b1, 32'h4000_0ABC, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h6000_0123, 32'h204, 1'b0, 1'b0);
    chk("two_in_ready", 64'(in_ready), 64'd0);
    chk("two_sel", 64'(selectSize), 64'd1);
    chk("two_imm22", 64'(imm22), 64'h000ABC);
    step(1'b1, 32'h0800_0001, 32'h208, 1'b0, 1'b0);
    chk("two_hold_pc", 64'(out_pc), 64'h200);

    // drain in order
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop_pc", 64'(out_pc), 64'h204);
    chk("pop_sel", 64'(selectSize), 64'd2);
    chk("pop_imm9", 64'(imm9), 64'h123);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // push+pop in ONE replaces head
    step(1'b1, 32'h8000_0007, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h8400_0009, 32'h304, 1'b1, 1'b0);
    chk("pp_pc", 64'(out_pc), 64'h304);
    chk("pp_sel", 64'(selectSize), 64'd3);
    chk("pp_imm18", 64'(imm18), 64'h00009);

    // flush overrides push and pop
    step(1'b1, 32'h0C00_0001, 32'h400, 1'b1, 1'b1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_pc", 64'(out_pc), 64'd0);

    // unassigned opcode 0x2A
    step(1'b1, {6'h2A, 26'h15}, 32'h500, 1'b0, 1'b0);
    chk("ill_sel", 64'(selectSize), 64'd0);
`ifdef ILLEGAL_OP_DETECT_EN
    chk("ill_flag", 64'(illegal), 64'd1);
`else
    chk("ill_flag", 64'(illegal), 64'd0);
`endif

    // reset while TWO, mid-cycle
    step(1'b1, 32'h1400_0002, 32'h504, 1'b0, 1'b0);
    chk("pre_rst_two", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_opc", 64'(opcode), 64'h10);
    in_valid = 1'b1;
    in_instr = 32'h0400_7777;
    in_pc    = 32'h600;
    @(posedge clock); #1;
    chk("rst_no_push", 64'(out_valid), 64'd0);
    reset = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // mixed traffic, model-checked every cycle
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_decode_reg.md
INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, instruction word loaded into empty/flushed entries.
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_pc  input  PC_W  address of in_instr.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held instructions.
REQ-010 SHALL have port out_valid  output  1  head entry holds a decoded instruction.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head entry.
REQ-012 SHALL have port out_pc  output  PC_W  PC of head entry.
REQ-013 SHALL have port opcode  output  6  head instr[31:26].
REQ-014 SHALL have port selectSize  output  2  immediate-size select for the sign extender.
REQ-015 SHALL have ports imm17 (16, instr[15:0]), imm22 (22, instr[21:0]), imm9 (12, instr[11:0]), imm18 (18, instr[17:0]), all outputs.
REQ-016 SHALL have port illegal  output  1  head opcode unassigned (see Configuration).

Function
REQ-017 SHALL be a 2-entry skid buffer, FSM states EMPTY, ONE, TWO.
REQ-018 SHALL push when in_valid&&in_ready; pop when out_valid&&out_ready.
REQ-019 Transitions SHALL be: EMPTY+push->ONE; ONE+push-only->TWO; ONE+pop-only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; otherwise hold.
REQ-020 in_ready SHALL equal (state!=TWO); out_valid SHALL equal (state!=EMPTY).
REQ-021 Push in cycle N SHALL make the entry visible at outputs in cycle N+1 (latency 1).
REQ-022 Order SHALL be strictly FIFO; the second entry is promoted to head on pop from TWO.
REQ-023 All decode outputs SHALL be combinational from head-entry registers only, stable while out_valid&&!out_ready.
REQ-024 selectSize SHALL be: opcode 0x00-0x0F->2'b00; 0x10-0x17->2'b01; 0x18-0x1F->2'b10; 0x20-0x27->2'b11; 0x28-0x3F->2'b00.
REQ-025 In EMPTY all decode outputs SHALL reflect NOP_WORD and out_pc SHALL be 0.
REQ-026 flush SHALL force EMPTY next cycle, overriding a same-cycle push and pop; entries reload NOP_WORD.
REQ-027 in_valid in TWO SHALL be ignored; upstream holds data until in_ready.

Reset
REQ-028 reset low SHALL immediately force EMPTY, entries=NOP_WORD, PCs=0, out_valid=0, in_ready=1, illegal=0.
REQ-029 Reset mid-operation SHALL discard all held entries; no push accepted while reset low.

Configuration
REQ-030 With ILLEGAL_OP_DETECT_EN defined, illegal SHALL be 1 when out_valid and head opcode in 0x28-0x3F.
REQ-031 Without ILLEGAL_OP_DETECT_EN, illegal SHALL be tied 0 and no detection logic instantiated.

Structure
REQ-032 Opcode-class ranges, selectSize encodings (I16=2'b00, I22=2'b01, I12=2'b10, I18=2'b11) and FSM state encoding SHALL live in shared package instr_pkg.
REQ-033 Field extraction and selectSize lookup SHALL be one combinational sub-module instr_field_decode.

Verification
REQ-034 Reset, push 32'h0400_1234 pc 0x100, out_ready=1 -> next cycle out_valid=1, selectSize=00, imm17=16'h1234, out_pc=0x100.
REQ-035 out_ready=0, push 32'h4000_0ABC then 32'h6000_0123 -> state TWO, in_ready=0, head selectSize=01 imm22=22'h000ABC; third push held.
REQ-036 From TWO, out_ready=1 two cycles -> heads pop in order, second selectSize=10 imm9=12'h123, then EMPTY.
REQ-037 State ONE, flush with in_valid and out_ready high -> next cycle EMPTY, out_valid=0, in_ready=1, pushed word lost.
REQ-038 Push opcode 0x2A with macro -> illegal=1, selectSize=00; without macro -> illegal=0.
REQ-039 Drop reset low while TWO -> out_valid=0 and in_ready=1 immediately, outputs reflect NOP_WORD.
